// File: rtl/spi_slave_regif_pkg.sv
// Shared definitions for the SPI slave register interface: default widths,
// command field layout, FSM state encoding and command decode helpers.
package spi_regif_pkg;

    localparam int CMD_W_DEF       = 8;
    localparam int DATA_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CMD_READ_BIT    = CMD_W_DEF - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD_RX    = 3'd1,
        DATA_RX   = 3'd2,
        DATA_TX   = 3'd3,
        DATA_DROP = 3'd4
    } state_t;

    // Register address carried in the low bits of a command byte.
    function automatic logic [CMD_W_DEF-2:0] cmd_addr(input logic [CMD_W_DEF-1:0] cmd);
        return cmd[CMD_W_DEF-2:0];
    endfunction

    // Direction flag of a command byte: 1 = read, 0 = write.
    function automatic logic cmd_is_read(input logic [CMD_W_DEF-1:0] cmd);
        return cmd[CMD_READ_BIT];
    endfunction

endpackage

// File: rtl/spi_slave_regif_if.sv
// Register-bank side bus of the SPI slave: write/read strobes, addresses,
// data and the discarded-frame pulse.
interface spi_slave_regif_if
    import spi_regif_pkg::*;
#(
    parameter int CMD_W  = CMD_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              wr_en;
    logic [CMD_W-2:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [CMD_W-2:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              frame_err;

    // SPI front end: issues strobes, consumes read data
    modport master (
        output wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err,
        input  rd_data
    );

    // Register bank: consumes strobes, returns read data
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err,
        output rd_data
    );

endinterface

// File: rtl/spi_slave_regif_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= {STAGES{RST_VAL}};
            prev_r  <= RST_VAL;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], din};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign level = chain_r[STAGES-1];
    assign rise  = chain_r[STAGES-1] & ~prev_r;
    assign fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns 8-bit command frames and 16-bit data frames
// into register-bank write strobes and read requests. SPI pins are
// oversampled in the clk domain.
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int CMD_W       = CMD_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_scl,
    input  logic spi_sdi,
    input  logic spi_cs_cmd,
    input  logic spi_cs_data,
    output logic spi_sdo,
    spi_slave_regif_if.master bus
);

    localparam int             CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

    // synchronized pin levels and edge pulses
    logic scl_rise_s, scl_lvl_unused, scl_fall_unused;
    logic sdi_lvl_s, sdi_rise_unused, sdi_fall_unused;
    logic cmd_lvl_s, cmd_rise_s, cmd_fall_s;
    logic data_lvl_s, data_rise_s, data_fall_s;

    // state and datapath registers
    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   rx_sr_r;
    logic [DATA_W-1:0]   tx_sr_r;
    logic [CMD_W-1:0]    cmd_r;
    logic                cmd_valid_r;
    logic                armed_r;
    logic [SYNC_STAGES-1:0] settle_r;
    logic                ld_r;

    // output registers
    logic              wr_en_r, rd_req_r, frame_err_r;
    logic [CMD_W-2:0]  wr_addr_r, rd_addr_r;
    logic [DATA_W-1:0] wr_data_r;

    // frame events and next-cycle strobe values
    logic start_cmd_s, start_data_s, start_both_s;
    logic abort_s, end_s;
    logic wr_en_d_s, rd_req_d_s, frame_err_d_s;
    logic cmd_load_s, cmd_clear_s;
    logic cmd_read_s;
    logic [CMD_W-2:0] cmd_addr_s;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (
        .clk(clk), .rst(rst), .din(spi_scl),
        .level(scl_lvl_unused), .rise(scl_rise_s), .fall(scl_fall_unused)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .din(spi_sdi),
        .level(sdi_lvl_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_cmd (
        .clk(clk), .rst(rst), .din(spi_cs_cmd),
        .level(cmd_lvl_s), .rise(cmd_rise_s), .fall(cmd_fall_s)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_data (
        .clk(clk), .rst(rst), .din(spi_cs_data),
        .level(data_lvl_s), .rise(data_rise_s), .fall(data_fall_s)
    );

    assign cmd_read_s = cmd_r[CMD_W-1];
    assign cmd_addr_s = cmd_r[CMD_W-2:0];

    // A start needs a clean idle bus (armed); the other CS must be high.
    assign start_cmd_s  = armed_r & cmd_fall_s & data_lvl_s;
    assign start_data_s = armed_r & data_fall_s & cmd_lvl_s;
    assign start_both_s = armed_r & (cmd_fall_s | data_fall_s) & ~cmd_lvl_s & ~data_lvl_s;

    // Per-state abort (foreign CS low) and normal end (own CS rise) events
    always_comb begin
        abort_s = 1'b0;
        end_s   = 1'b0;
        case (state_r)
            CMD_RX: begin
                abort_s = ~data_lvl_s;
                end_s   = cmd_rise_s;
            end
            DATA_RX, DATA_TX, DATA_DROP: begin
                abort_s = ~cmd_lvl_s;
                end_s   = data_rise_s;
            end
            default: begin
                abort_s = 1'b0;
                end_s   = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_cmd_s) begin
                    state_nxt_s = CMD_RX;
                end else if (start_data_s) begin
                    if (!cmd_valid_r) begin
                        state_nxt_s = DATA_DROP;
                    end else if (cmd_read_s) begin
                        state_nxt_s = DATA_TX;
                    end else begin
                        state_nxt_s = DATA_RX;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMD_RX, DATA_RX, DATA_TX, DATA_DROP: begin
                if (abort_s || end_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: next-cycle strobes and command register control
    always_comb begin
        wr_en_d_s     = 1'b0;
        rd_req_d_s    = 1'b0;
        frame_err_d_s = 1'b0;
        cmd_load_s    = 1'b0;
        cmd_clear_s   = 1'b0;
        case (state_r)
            IDLE: begin
                rd_req_d_s    = start_data_s & cmd_valid_r & cmd_read_s;
                frame_err_d_s = start_both_s;
            end
            CMD_RX: begin
                if (abort_s) begin
                    frame_err_d_s = 1'b1;
                    cmd_clear_s   = 1'b1;
                end else if (end_s) begin
                    if (cnt_r == CNT_CMD) begin
                        cmd_load_s = 1'b1;
                    end else begin
                        frame_err_d_s = 1'b1;
                        cmd_clear_s   = 1'b1;
                    end
                end else begin
                    cmd_load_s = 1'b0;
                end
            end
            DATA_RX: begin
                if (abort_s) begin
                    frame_err_d_s = 1'b1;
                end else if (end_s) begin
                    if (cnt_r == CNT_DATA) begin
                        wr_en_d_s = 1'b1;
                    end else begin
                        frame_err_d_s = 1'b1;
                    end
                end else begin
                    wr_en_d_s = 1'b0;
                end
            end
            DATA_TX: begin
                if (abort_s) begin
                    frame_err_d_s = 1'b1;
                end else if (end_s && (cnt_r != CNT_DATA)) begin
                    frame_err_d_s = 1'b1;
                end else begin
                    frame_err_d_s = 1'b0;
                end
            end
            DATA_DROP: begin
                frame_err_d_s = abort_s | end_s;
            end
            default: begin
                frame_err_d_s = 1'b0;
            end
        endcase
    end

    // Start gating: no start until the synchronizers hold real pin samples
    // and both selects have been seen high; cleared again by any abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_r <= '0;
            armed_r  <= 1'b0;
        end else begin
            settle_r <= {settle_r[SYNC_STAGES-2:0], 1'b1};
            if (abort_s || start_both_s) begin
                armed_r <= 1'b0;
            end else if (settle_r[SYNC_STAGES-1] && cmd_lvl_s && data_lvl_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Bit counter (saturating) and receive shift register, cleared in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            rx_sr_r <= '0;
        end else if (state_r == IDLE) begin
            cnt_r   <= '0;
            rx_sr_r <= '0;
        end else if (scl_rise_s) begin
            cnt_r   <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            rx_sr_r <= {rx_sr_r[DATA_W-2:0], sdi_lvl_s};
        end else begin
            cnt_r   <= cnt_r;
            rx_sr_r <= rx_sr_r;
        end
    end

    // Command register; survives data frames so repeated data frames reuse it
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r       <= '0;
            cmd_valid_r <= 1'b0;
        end else if (cmd_load_s) begin
            cmd_r       <= rx_sr_r[CMD_W-1:0];
            cmd_valid_r <= 1'b1;
        end else if (cmd_clear_s) begin
            cmd_r       <= cmd_r;
            cmd_valid_r <= 1'b0;
        end else begin
            cmd_r       <= cmd_r;
            cmd_valid_r <= cmd_valid_r;
        end
    end

    // Transmit shift register: loaded the cycle after rd_data is valid,
    // shifted after each SCL rise; zero outside DATA_TX so sdo idles low
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_r    <= 1'b0;
            tx_sr_r <= '0;
        end else begin
            ld_r <= rd_req_r;
            if (state_nxt_s != DATA_TX) begin
                tx_sr_r <= '0;
            end else if (ld_r) begin
                tx_sr_r <= bus.rd_data;
            end else if (scl_rise_s) begin
                tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
            end else begin
                tx_sr_r <= tx_sr_r;
            end
        end
    end

    // Registered register-bank strobes with their address/data qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            rd_req_r    <= 1'b0;
            rd_addr_r   <= '0;
            frame_err_r <= 1'b0;
        end else begin
            wr_en_r     <= wr_en_d_s;
            rd_req_r    <= rd_req_d_s;
            frame_err_r <= frame_err_d_s;
            if (wr_en_d_s) begin
                wr_addr_r <= cmd_addr_s;
                wr_data_r <= rx_sr_r;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
            if (rd_req_d_s) begin
                rd_addr_r <= cmd_addr_s;
            end else begin
                rd_addr_r <= rd_addr_r;
            end
        end
    end

    assign spi_sdo       = tx_sr_r[DATA_W-1];
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.rd_req    = rd_req_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: bit-banged SPI master, register-bank
// model answering reads one clock after rd_req, per-feature test tasks.
module tb_spi_slave_regif;
    import spi_regif_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b0;
    logic sdi = 1'b0;
    logic cs_cmd = 1'b1;
    logic cs_data = 1'b1;
    logic sdo;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;
    int clash_cnt = 0;
    logic [6:0]  last_wr_addr = 7'd0;
    logic [15:0] last_wr_data = 16'd0;
    logic [6:0]  last_rd_addr = 7'h7f;
    logic [15:0] mem [0:127];
    bit          use_sum = 1'b0;
    logic [15:0] rd_fixed = 16'h0000;

    spi_slave_regif_if #(.CMD_W(8), .DATA_W(16)) bus ();

    spi_slave_regif #(.CMD_W(8), .DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_scl(scl), .spi_sdi(sdi),
        .spi_cs_cmd(cs_cmd), .spi_cs_data(cs_data),
        .spi_sdo(sdo),
        .bus(bus.master)
    );

    always #10 clk = ~clk;

    initial begin
        bus.rd_data = 16'h0000;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    end

    // strobe monitor and write side of the register-bank model
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            last_wr_addr = bus.wr_addr;
            last_wr_data = bus.wr_data;
            mem[bus.wr_addr] = bus.wr_data;
        end
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.wr_en === 1'b1 && bus.rd_req === 1'b1) clash_cnt++;
    end

    // read side of the bank model: data valid only during the clock after rd_req
    always begin
        @(negedge clk);
        if (bus.rd_req === 1'b1) begin
            rd_cnt++;
            last_rd_addr = bus.rd_addr;
            @(posedge clk);
            #1;
            if (bus.rd_addr == 7'd0 && use_sum) bus.rd_data = mem[1] + mem[2] + mem[3];
            else if (bus.rd_addr == 7'd0)       bus.rd_data = rd_fixed;
            else                                bus.rd_data = mem[bus.rd_addr];
            @(posedge clk);
            #1;
            bus.rd_data = 16'h0000;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // one SPI frame: mode 0, MSB first, SCL half period 50 ns
    task automatic spi_frame(input bit is_data, input int nbits, input logic [31:0] word,
                             output logic [15:0] rx);
        rx = 16'h0000;
        @(negedge clk);
        #3;
        if (is_data) cs_data = 1'b0; else cs_cmd = 1'b0;
        #200;
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = word[i];
            #50;
            scl = 1'b1;
            rx = {rx[14:0], sdo};
            #50;
            scl = 1'b0;
        end
        sdi = 1'b0;
        #50;
        if (is_data) cs_data = 1'b1; else cs_cmd = 1'b1;
        #300;
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [15:0] data);
        logic [15:0] dummy;
        spi_frame(1'b0, 8, {24'd0, 1'b0, addr}, dummy);
        spi_frame(1'b1, 16, {16'd0, data}, dummy);
    endtask

    task automatic do_read(output logic [15:0] data);
        logic [15:0] dummy;
        spi_frame(1'b0, 8, 32'h0000_0080, dummy);
        spi_frame(1'b1, 16, 32'h0000_0000, data);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({bus.wr_en, bus.rd_req, bus.frame_err, sdo} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 0000", {bus.wr_en, bus.rd_req, bus.frame_err, sdo});
        end
        total++;
        if ({bus.wr_addr, bus.wr_data} !== 23'd0) begin
            bad++;
            $display("FAIL reset_wr_bus: got %h want 0", {bus.wr_addr, bus.wr_data});
        end
        total++;
        if (bus.rd_addr !== 7'd0) begin
            bad++;
            $display("FAIL reset_rd_addr: got %h want 0", bus.rd_addr);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        do_write(7'd1, 16'h1234);
        total++;
        if (wr_cnt - w0 != 1) begin bad++; $display("FAIL write_count: got %0d want 1", wr_cnt - w0); end
        total++;
        if (last_wr_addr !== cmd_addr(8'h01)) begin bad++; $display("FAIL write_addr: got %h want 01", last_wr_addr); end
        total++;
        if (last_wr_data !== 16'h1234) begin bad++; $display("FAIL write_data: got %h want 1234", last_wr_data); end
        total++;
        if (err_cnt != e0) begin bad++; $display("FAIL write_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_read();
        logic [15:0] v;
        logic [15:0] dummy;
        int r0 = rd_cnt;
        int e0 = err_cnt;
        use_sum = 1'b0;
        rd_fixed = 16'hBEEF;
        do_read(v);
        total++;
        if (v !== 16'hBEEF) begin bad++; $display("FAIL read_data: got %h want beef", v); end
        total++;
        if (rd_cnt - r0 != 1) begin bad++; $display("FAIL read_count: got %0d want 1", rd_cnt - r0); end
        total++;
        if (last_rd_addr !== 7'd0) begin bad++; $display("FAIL read_addr: got %h want 00", last_rd_addr); end
        total++;
        if (sdo !== 1'b0) begin bad++; $display("FAIL read_sdo_idle: got %b want 0", sdo); end
        // a second data frame reuses the stored read command
        spi_frame(1'b1, 16, 32'h0, dummy);
        total++;
        if (dummy !== 16'hBEEF) begin bad++; $display("FAIL read_reuse: got %h want beef", dummy); end
        total++;
        if (rd_cnt - r0 != 2 || err_cnt != e0) begin
            bad++;
            $display("FAIL read_reuse_count: got rd=%0d err=%0d want rd=2 err=0", rd_cnt - r0, err_cnt - e0);
        end
    endtask

    task automatic test_sum_loop();
        logic [15:0] a, b, c, v, expv;
        use_sum = 1'b1;
        for (int it = 0; it < 10; it++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            do_write(7'd1, a);
            do_write(7'd2, b);
            do_write(7'd3, c);
            expv = a + b + c;
            do_read(v);
            total++;
            if (v !== expv) begin bad++; $display("FAIL sum_loop[%0d]: got %h want %h", it, v, expv); end
        end
        use_sum = 1'b0;
    endtask

    task automatic test_short_frames();
        logic [15:0] dummy;
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        int e0 = err_cnt;
        spi_frame(1'b0, 5, 32'h0000_0001, dummy);
        spi_frame(1'b1, 16, 32'h0000_AAAA, dummy);
        total++;
        if (err_cnt - e0 != 2) begin bad++; $display("FAIL short_cmd_err: got %0d want 2", err_cnt - e0); end
        total++;
        if (wr_cnt != w0 || rd_cnt != r0) begin
            bad++;
            $display("FAIL short_cmd_strobes: got wr=%0d rd=%0d want 0 0", wr_cnt - w0, rd_cnt - r0);
        end
        spi_frame(1'b0, 8, 32'h0000_0005, dummy);
        spi_frame(1'b1, 15, 32'h0000_1111, dummy);
        spi_frame(1'b1, 17, 32'h0001_2222, dummy);
        total++;
        if (err_cnt - e0 != 4 || wr_cnt != w0) begin
            bad++;
            $display("FAIL data_len_err: got err=%0d wr=%0d want err=4 wr=0", err_cnt - e0, wr_cnt - w0);
        end
        spi_frame(1'b1, 16, 32'h0000_C0DE, dummy);
        total++;
        if (wr_cnt - w0 != 1 || last_wr_addr !== 7'd5 || last_wr_data !== 16'hC0DE) begin
            bad++;
            $display("FAIL data_len_ok: got wr=%0d addr=%h data=%h want 1 05 c0de", wr_cnt - w0, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_abort();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        do_write(7'd3, 16'h0F0F);
        @(negedge clk);
        #3;
        cs_data = 1'b0;
        #200;
        for (int i = 0; i < 5; i++) begin
            sdi = 1'b1; #50; scl = 1'b1; #50; scl = 1'b0;
        end
        cs_cmd = 1'b0;
        #300;
        cs_cmd = 1'b1;
        cs_data = 1'b1;
        sdi = 1'b0;
        #300;
        total++;
        if (err_cnt - e0 != 1 || wr_cnt - w0 != 1) begin
            bad++;
            $display("FAIL abort: got err=%0d wr=%0d want err=1 wr=1", err_cnt - e0, wr_cnt - w0);
        end
        do_write(7'd3, 16'h5A5A);
        total++;
        if (wr_cnt - w0 != 2 || last_wr_data !== 16'h5A5A) begin
            bad++;
            $display("FAIL abort_recover: got wr=%0d data=%h want 2 5a5a", wr_cnt - w0, last_wr_data);
        end
    endtask

    task automatic test_cs_low_at_reset();
        int w0, e0;
        @(negedge clk);
        rst = 1'b1;
        cs_cmd = 1'b0;
        cs_data = 1'b0;
        repeat (5) @(negedge clk);
        w0 = wr_cnt;
        e0 = err_cnt;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        cs_cmd = 1'b1;
        cs_data = 1'b1;
        repeat (10) @(negedge clk);
        do_write(7'd2, 16'h00FF);
        total++;
        if (wr_cnt - w0 != 1 || last_wr_addr !== 7'd2 || last_wr_data !== 16'h00FF) begin
            bad++;
            $display("FAIL cs_low_reset_write: got wr=%0d addr=%h data=%h want 1 02 00ff", wr_cnt - w0, last_wr_addr, last_wr_data);
        end
        total++;
        if (err_cnt != e0) begin bad++; $display("FAIL cs_low_reset_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_rst_mid_frame();
        logic [15:0] dummy;
        int w0, e0;
        spi_frame(1'b0, 8, 32'h0000_0001, dummy);
        w0 = wr_cnt;
        e0 = err_cnt;
        @(negedge clk);
        #3;
        cs_data = 1'b0;
        #200;
        for (int i = 0; i < 9; i++) begin
            sdi = ~sdi; #50; scl = 1'b1; #50; scl = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.wr_en, bus.rd_req, bus.frame_err, sdo, bus.wr_addr, bus.wr_data, bus.rd_addr} !== 37'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h want 0",
                     {bus.wr_en, bus.rd_req, bus.frame_err, sdo, bus.wr_addr, bus.wr_data, bus.rd_addr});
        end
        rst = 1'b0;
        @(negedge clk);
        #3;
        for (int i = 0; i < 7; i++) begin
            sdi = ~sdi; #50; scl = 1'b1; #50; scl = 1'b0;
        end
        #50;
        cs_data = 1'b1;
        sdi = 1'b0;
        #300;
        total++;
        if (wr_cnt != w0 || err_cnt != e0) begin
            bad++;
            $display("FAIL rst_mid_nostrobe: got wr=%0d err=%0d want 0 0", wr_cnt - w0, err_cnt - e0);
        end
        do_write(7'd1, 16'hABCD);
        total++;
        if (wr_cnt - w0 != 1 || last_wr_addr !== 7'd1 || last_wr_data !== 16'hABCD) begin
            bad++;
            $display("FAIL rst_mid_recover: got wr=%0d addr=%h data=%h want 1 01 abcd", wr_cnt - w0, last_wr_addr, last_wr_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_sum_loop();
        test_short_frames();
        test_abort();
        test_cs_low_at_reset();
        test_rst_mid_frame();
        total++;
        if (clash_cnt != 0) begin bad++; $display("FAIL strobe_clash: got %0d want 0", clash_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
